// File: rtl/tcp_chksum_calc.sv
// TCP checksum engine: sums pseudo-header, TCP core header and payload beats
// into a 32-bit ones-complement accumulator, folds it, and hands out the result.
module tcp_chksum_calc #(
  parameter int DATA_W     = 64,
  parameter int PADBYTES_W = $clog2(DATA_W/8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hdr_val,
  input  logic [95:0]           hdr_pseudo,
  input  logic [159:0]          hdr_tcp,
  output logic                  hdr_rdy,
  input  logic                  data_val,
  input  logic [DATA_W-1:0]     data,
  input  logic                  data_last,
  input  logic [PADBYTES_W-1:0] data_padbytes,
  output logic                  data_rdy,
  output logic                  chksum_val,
  output logic [15:0]           chksum,
  output logic                  chksum_len_err,
  input  logic                  chksum_rdy
);

  localparam int BYTES = DATA_W / 8;
  localparam int WORDS = DATA_W / 16;
  localparam int CNT_W = PADBYTES_W + 1;

  typedef enum logic [2:0] {IDLE, HDR, DATA, FOLD, OUT} state_t;

  state_t        state;
  logic [95:0]   pseudo_q;
  logic [159:0]  tcp_q;
  logic [31:0]   acc;
  logic [23:0]   byte_cnt;
  logic [15:0]   exp_bytes;
  logic [1:0]    phase;
  logic          len_err;

  logic [15:0]       hdr_words [16];
  logic [31:0]       hdr_sum;
  logic [CNT_W-1:0]  valid_bytes;
  logic [DATA_W-1:0] masked;
  logic [31:0]       beat_sum;
  logic [23:0]       cnt_next;
  logic [31:0]       fold;
  logic [15:0]       in_len;

  // Header word order: 6 pseudo-header words then 10 TCP words; TCP word 8 is the checksum field.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) hdr_words[i] = '0;
    for (int unsigned i = 0; i < 6; i++)  hdr_words[i] = pseudo_q[95-16*i -: 16];
    for (int unsigned i = 0; i < 10; i++) hdr_words[6+i] = tcp_q[159-16*i -: 16];
    hdr_words[14] = '0;
  end

  always_comb begin
    hdr_sum = '0;
    for (int unsigned k = 0; k < 4; k++)
      hdr_sum = hdr_sum + {16'h0000, hdr_words[{phase, k[1:0]}]};
  end

  always_comb begin
    valid_bytes = data_last ? CNT_W'(BYTES) - {1'b0, data_padbytes} : CNT_W'(BYTES);
    masked = '0;
    for (int unsigned b = 0; b < BYTES; b++)
      if (CNT_W'(b) < valid_bytes)
        masked[DATA_W-1-8*b -: 8] = data[DATA_W-1-8*b -: 8];
    beat_sum = '0;
    for (int unsigned w = 0; w < WORDS; w++)
      beat_sum = beat_sum + {16'h0000, masked[DATA_W-1-16*w -: 16]};
    cnt_next = byte_cnt + 24'(valid_bytes);
  end

  assign fold   = {16'h0000, acc[15:0]} + {16'h0000, acc[31:16]};
  assign in_len = hdr_pseudo[31:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pseudo_q       <= '0;
      tcp_q          <= '0;
      acc            <= '0;
      byte_cnt       <= '0;
      exp_bytes      <= '0;
      phase          <= '0;
      len_err        <= 1'b0;
      hdr_rdy        <= 1'b0;
      data_rdy       <= 1'b0;
      chksum_val     <= 1'b0;
      chksum         <= '0;
      chksum_len_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hdr_rdy <= 1'b1;
          if (hdr_val && hdr_rdy) begin
            hdr_rdy   <= 1'b0;
            pseudo_q  <= hdr_pseudo;
            tcp_q     <= hdr_tcp;
            acc       <= '0;
            byte_cnt  <= '0;
            phase     <= '0;
            len_err   <= (in_len < 16'd20);
            exp_bytes <= (in_len < 16'd20) ? 16'd0 : in_len - 16'd20;
            state     <= HDR;
          end
        end
        HDR: begin
          acc   <= acc + hdr_sum;
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            if (exp_bytes != 16'd0) begin
              state    <= DATA;
              data_rdy <= 1'b1;
            end else begin
              state <= FOLD;
            end
          end
        end
        DATA: begin
          if (data_val && data_rdy) begin
            acc      <= acc + beat_sum;
            byte_cnt <= cnt_next;
            if (data_last) begin
              if (cnt_next != {8'h00, exp_bytes}) len_err <= 1'b1;
              data_rdy <= 1'b0;
              phase    <= '0;
              state    <= FOLD;
            end
          end
        end
        FOLD: begin
          acc   <= fold;
          phase <= phase + 2'd1;
          if (phase == 2'd1) begin
            phase          <= '0;
            chksum_val     <= 1'b1;
            chksum         <= ~fold[15:0];
            chksum_len_err <= len_err;
            state          <= OUT;
          end
        end
        OUT: begin
          if (chksum_rdy) begin
            chksum_val     <= 1'b0;
            chksum_len_err <= 1'b0;
            hdr_rdy        <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_chksum_calc.sv
// Bench for tcp_chksum_calc: vector table plus reset/latency sequences,
// results checked through an expected-value queue.
module tb_tcp_chksum_calc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hdr_val = 1'b0;
  logic [95:0]  hdr_pseudo = '0;
  logic [159:0] hdr_tcp = '0;
  logic         hdr_rdy;
  logic         data_val = 1'b0;
  logic [63:0]  data = '0;
  logic         data_last = 1'b0;
  logic [2:0]   data_padbytes = '0;
  logic         data_rdy;
  logic         chksum_val;
  logic [15:0]  chksum;
  logic         chksum_len_err;
  logic         chksum_rdy = 1'b0;

  tcp_chksum_calc #(.DATA_W(64), .PADBYTES_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_val(hdr_val), .hdr_pseudo(hdr_pseudo), .hdr_tcp(hdr_tcp), .hdr_rdy(hdr_rdy),
    .data_val(data_val), .data(data), .data_last(data_last),
    .data_padbytes(data_padbytes), .data_rdy(data_rdy),
    .chksum_val(chksum_val), .chksum(chksum), .chksum_len_err(chksum_len_err),
    .chksum_rdy(chksum_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0]  ps;
    logic [159:0] tcp;
    int           nbeats;
    logic [63:0]  b0;
    logic [63:0]  b1;
    logic [2:0]   pad;
    logic [15:0]  ck;
    logic         err;
  } vec_t;

  typedef struct {
    logic [15:0] ck;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t v[12];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] mk_ps(input logic [31:0] src, input logic [31:0] dst,
                                        input logic [15:0] len, input logic [7:0] proto);
    return {src, dst, len, 8'h00, proto};
  endfunction

  function automatic vec_t mkv(input logic [95:0] ps, input logic [159:0] tcp, input int nb,
                               input logic [63:0] b0, input logic [63:0] b1, input logic [2:0] pad,
                               input logic [15:0] ck, input logic err);
    vec_t r;
    r.ps = ps; r.tcp = tcp; r.nbeats = nb; r.b0 = b0; r.b1 = b1;
    r.pad = pad; r.ck = ck; r.err = err;
    return r;
  endfunction

  task automatic send_hdr(input logic [95:0] ps, input logic [159:0] tcp);
    int t = 0;
    @(negedge clk);
    while (!hdr_rdy && t < 50) begin @(negedge clk); t++; end
    if (!hdr_rdy) chk("hdr_rdy_timeout", 32'(hdr_rdy), 32'd1);
    hdr_pseudo = ps;
    hdr_tcp    = tcp;
    hdr_val    = 1'b1;
    @(posedge clk);
    #1 hdr_val = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input logic [2:0] pad);
    int t = 0;
    @(negedge clk);
    while (!data_rdy && t < 50) begin @(negedge clk); t++; end
    if (!data_rdy) chk("data_rdy_timeout", 32'(data_rdy), 32'd1);
    data = d; data_last = last; data_padbytes = pad; data_val = 1'b1;
    @(posedge clk);
    #1 begin data_val = 1'b0; data_last = 1'b0; data_padbytes = '0; end
  endtask

  task automatic get_result(input int hold);
    int t = 0;
    exp_t e;
    @(negedge clk);
    while (!chksum_val && t < 100) begin @(negedge clk); t++; end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    if (!chksum_val) begin
      chk("chksum_val_timeout", 32'(chksum_val), 32'd1);
      return;
    end
    chk("chksum", 32'(chksum), 32'(e.ck));
    chk("len_err", 32'(chksum_len_err), 32'(e.err));
    chk("hdr_rdy_while_out", 32'(hdr_rdy), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_val", 32'(chksum_val), 32'd1);
      chk("hold_chksum", 32'(chksum), 32'(e.ck));
    end
    chksum_rdy = 1'b1;
    @(posedge clk);
    #1 chksum_rdy = 1'b0;
    @(negedge clk);
    chk("val_after_accept", 32'(chksum_val), 32'd0);
    chk("idle_after_accept", 32'(hdr_rdy), 32'd1);
  endtask

  task automatic run_vec(input vec_t x);
    exp_t e;
    send_hdr(x.ps, x.tcp);
    e.ck = x.ck; e.err = x.err;
    sb.push_back(e);
    if (x.nbeats >= 1) send_beat(x.b0, x.nbeats == 1, x.nbeats == 1 ? x.pad : 3'd0);
    if (x.nbeats == 2) send_beat(x.b1, 1'b1, x.pad);
    get_result(1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_hdr_rdy"}, 32'(hdr_rdy), 32'd0);
    chk({tag, "_data_rdy"}, 32'(data_rdy), 32'd0);
    chk({tag, "_chksum_val"}, 32'(chksum_val), 32'd0);
    chk({tag, "_chksum"}, 32'(chksum), 32'd0);
    chk({tag, "_len_err"}, 32'(chksum_len_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    v[0]  = mkv(mk_ps(0, 0, 16'd20, 8'd6), '0, 0, '0, '0, 3'd0, 16'hFFE5, 1'b0);
    v[1]  = mkv(mk_ps(0, 0, 16'd20, 8'd6), {128'h0, 16'h1234, 16'h0}, 0, '0, '0, 3'd0, 16'hFFE5, 1'b0);
    v[2]  = mkv(mk_ps(0, 0, 16'd20, 8'd0), {128'h0, 16'h1234, 16'h0}, 0, '0, '0, 3'd0, 16'hFFEB, 1'b0);
    v[3]  = mkv(mk_ps(0, 0, 16'd28, 8'd0), '0, 1, 64'hFFFF_FFFF_FFFF_FFFF, '0, 3'd0, 16'hFFE3, 1'b0);
    v[4]  = mkv(mk_ps(0, 0, 16'd21, 8'd0), '0, 1, 64'hABCD_CDCD_CDCD_CDCD, '0, 3'd7, 16'h54EA, 1'b0);
    v[5]  = mkv(mk_ps(0, 0, 16'd36, 8'd0), '0, 1, 64'h0, '0, 3'd0, 16'hFFDB, 1'b1);
    v[6]  = mkv(mk_ps(0, 0, 16'd36, 8'd6), '0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                3'd0, 16'hFFD5, 1'b0);
    v[7]  = mkv(mk_ps(0, 0, 16'd10, 8'd0), '0, 0, '0, '0, 3'd0, 16'hFFF5, 1'b1);
    v[8]  = mkv(mk_ps(32'h0A00_0001, 32'h0A00_0002, 16'd20, 8'd6), {16'h1234, 16'h5678, 128'h0},
                0, '0, '0, 3'd0, 16'h8336, 1'b0);
    v[9]  = mkv(mk_ps(0, 0, 16'd20, 8'd6), {16'hFFE5, 144'h0}, 0, '0, '0, 3'd0, 16'h0000, 1'b0);
    v[10] = mkv(mk_ps(0, 0, 16'd23, 8'd0), '0, 1, 64'h1122_33FF_FFFF_FFFF, '0, 3'd5, 16'hBBC6, 1'b0);
    v[11] = mkv(mk_ps(0, 0, 16'd28, 8'd0), '0, 2, 64'h0001_0000_0000_0000, 64'h0002_0000_0000_0000,
                3'd0, 16'hFFE0, 1'b1);

    #2 chk_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("hdr_rdy_after_reset", 32'(hdr_rdy), 32'd1);

    // Zero-payload packet: result must appear exactly on the 6th edge after the transfer.
    send_hdr(mk_ps(0, 0, 16'd20, 8'd6), '0);
    e.ck = 16'hFFE5; e.err = 1'b0;
    sb.push_back(e);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("latency_edge5", 32'(chksum_val), 32'd0);
    chk("no_data_rdy", 32'(data_rdy), 32'd0);
    @(posedge clk);
    get_result(3);

    for (int i = 0; i < 12; i++) run_vec(v[i]);

    // Abort mid-payload with reset, then the plain packet must come out clean.
    send_hdr(mk_ps(0, 0, 16'd36, 8'd0), '0);
    send_beat(64'h1111_2222_3333_4444, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_outputs_zero("midreset");
    @(negedge clk);
    chk_outputs_zero("midreset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk("hdr_rdy_after_midreset", 32'(hdr_rdy), 32'd1);
    run_vec(v[0]);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
